// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage controller for the pRISC core.
// Drives the PC register's next value every cycle, runs the instruction
// memory req/ack handshake, presents fetched words to decode over a
// valid/ready interface, applies redirects from execute (including ones
// that arrive while a fetch is outstanding) and halts at instruction
// boundaries.
module pc_sequencer #(
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
    parameter logic [31:0] STEP      = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir_data,
    output logic [31:0] ir_pc,
    input  logic        ir_ready,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        halt,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      resume_state;
    logic        pend_valid;
    logic [31:0] pend_target;
    logic [31:0] redir_aligned;
    logic        redir_accept;

    // Targets are always word aligned; the dropped low bits only feed misalign.
    assign redir_aligned = {redir_target[31:2], 2'b00};
    // Redirects are ignored only while booting.
    assign redir_accept  = redir_valid && (state != BOOT);
    // Every path that would start a new fetch parks in HALTED instead when halt is up.
    assign resume_state  = halt ? HALTED : FETCH;

    // Next-PC selection and fetch request, combinational from state and inputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        pc_next   = pc_cur;
        imem_req  = 1'b0;
        imem_addr = pc_cur;
        case (state)
            BOOT: begin
                pc_next = BOOT_ADDR;
            end
            FETCH: begin
                // pc_cur is held until the ack, which keeps imem_addr stable.
                imem_req = 1'b1;
                if (imem_ack) begin
                    if (redir_valid) begin
                        pc_next = redir_aligned;
                    end else if (pend_valid) begin
                        pc_next = pend_target;
                    end
                end
            end
            ISSUE: begin
                if (redir_valid) begin
                    pc_next = redir_aligned;
                end else if (ir_ready) begin
                    pc_next = pc_cur + STEP;
                end
            end
            HALTED: begin
                if (redir_valid) begin
                    pc_next = redir_aligned;
                end
            end
            default: begin
                pc_next = BOOT_ADDR;
            end
        endcase
    end

    // Sequencer state, instruction register, deferred redirect and misalign flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BOOT;
            ir_valid    <= 1'b0;
            ir_data     <= 32'd0;
            ir_pc       <= 32'd0;
            misalign    <= 1'b0;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // branch below reads the pre-edge values of state and pend.
            if (redir_accept && (redir_target[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
            case (state)
                BOOT: begin
                    state <= resume_state;
                end
                FETCH: begin
                    if (imem_ack) begin
                        pend_valid  <= 1'b0;
                        pend_target <= 32'd0;
                        if (redir_valid || pend_valid) begin
                            // Data belongs to the old path; drop it and refetch.
                            state <= resume_state;
                        end else begin
                            ir_data  <= imem_rdata;
                            ir_pc    <= pc_cur;
                            ir_valid <= 1'b1;
                            state    <= ISSUE;
                        end
                    end else if (redir_valid) begin
                        // Remember the newest target until the outstanding fetch returns.
                        pend_valid  <= 1'b1;
                        pend_target <= redir_aligned;
                    end
                end
                ISSUE: begin
                    // A redirect squashes the instruction even if decode is ready.
                    if (redir_valid || ir_ready) begin
                        ir_valid <= 1'b0;
                        state    <= resume_state;
                    end
                end
                HALTED: begin
                    if (!halt) begin
                        state <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by a randomized
// run checked against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ir_valid;
    logic [31:0] ir_data;
    logic [31:0] ir_pc;
    logic        ir_ready;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        halt;
    logic        misalign;

    logic [31:0] pc_reg;
    logic        ovr_en;
    logic [31:0] ovr_val;

    int n_cmp;
    int n_err;

    pc_sequencer #(
        .BOOT_ADDR(32'h0000_0000),
        .STEP     (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ir_valid    (ir_valid),
        .ir_data     (ir_data),
        .ir_pc       (ir_pc),
        .ir_ready    (ir_ready),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .halt        (halt),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External PC register: resets to FFFF_FFFC and loads pc_next every clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_reg <= 32'hFFFF_FFFC;
        else     pc_reg <= pc_next;
    end
    assign pc_cur = ovr_en ? ovr_val : pc_reg;

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction
    assign imem_rdata = mem_word(imem_addr);

    // Advance to just after the next falling edge.
    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; imem_ack = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0;
        redir_target = 32'd0; halt = 1'b0; ovr_en = 1'b0; ovr_val = 32'd0;
        cyc();
        cyc();
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
        n_cmp++; if (ir_data !== 32'd0) begin n_err++; $display("FAIL rst_ir_data: got %h want 0", ir_data); end
        n_cmp++; if (ir_pc !== 32'd0) begin n_err++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
        n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", misalign); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_imem_req: got %b want 0", imem_req); end
        n_cmp++; if (pc_next !== 32'd0) begin n_err++; $display("FAIL rst_pc_next: got %h want 0", pc_next); end
        rst = 1'b0;
        #1;
        n_cmp++; if (pc_next !== 32'd0) begin n_err++; $display("FAIL boot_pc_next: got %h want 0", pc_next); end
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req: got %b want 0", imem_req); end
        cyc();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL first_req: got %b want 1", imem_req); end
        n_cmp++; if (imem_addr !== 32'd0) begin n_err++; $display("FAIL first_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_zero_wait();
        imem_ack = 1'b1; ir_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid[%0d]: got %b want 1", k, ir_valid); end
            n_cmp++; if (ir_pc !== 32'(4 * k)) begin n_err++; $display("FAIL zw_ir_pc[%0d]: got %h want %h", k, ir_pc, 32'(4 * k)); end
            n_cmp++; if (ir_data !== mem_word(32'(4 * k))) begin n_err++; $display("FAIL zw_ir_data[%0d]: got %h want %h", k, ir_data, mem_word(32'(4 * k))); end
            cyc();
            n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL zw_gap[%0d]: got %b want 0", k, ir_valid); end
            n_cmp++; if (imem_addr !== 32'(4 * k + 4)) begin n_err++; $display("FAIL zw_addr[%0d]: got %h want %h", k, imem_addr, 32'(4 * k + 4)); end
        end
        cyc();
        // In ISSUE: force the PC to the top of the address space.
        ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFC; imem_ack = 1'b0;
        #1;
        n_cmp++; if (pc_next !== 32'd0) begin n_err++; $display("FAIL wrap_pc_next: got %h want 0", pc_next); end
        cyc();
        ovr_en = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin n_err++; $display("FAIL wrap_fetch: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_redirect_pending();
        ir_ready = 1'b0;
        imem_ack = 1'b1; redir_valid = 1'b1; redir_target = 32'h8;
        #1;
        n_cmp++; if (pc_next !== 32'h8) begin n_err++; $display("FAIL rd_to8: got %h want 8", pc_next); end
        cyc();
        imem_ack = 1'b0; redir_valid = 1'b1; redir_target = 32'h100;
        #1;
        n_cmp++; if (imem_addr !== 32'h8 || pc_next !== 32'h8) begin n_err++; $display("FAIL rd_wait1: got addr=%h next=%h want 8/8", imem_addr, pc_next); end
        cyc();
        redir_target = 32'h200;
        #1;
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL rd_wait2_addr: got %h want 8", imem_addr); end
        cyc();
        redir_valid = 1'b0;
        cyc();
        imem_ack = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 32'h200) begin n_err++; $display("FAIL rd_ack_next: got %h want 200", pc_next); end
        cyc();
        imem_ack = 1'b0;
        #1;
        n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL rd_dropped: got ir_valid=%b want 0", ir_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL rd_refetch: got req=%b addr=%h want 1/200", imem_req, imem_addr); end
    endtask

    task automatic test_backpressure();
        imem_ack = 1'b1; ir_ready = 1'b0;
        cyc();
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'h200 || ir_data !== mem_word(32'h200)) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b pc=%h d=%h", i, ir_valid, ir_pc, ir_data);
            end
            n_cmp++; if (imem_req !== 1'b0 || pc_next !== 32'h200) begin
                n_err++; $display("FAIL bp_idle[%0d]: got req=%b next=%h want 0/200", i, imem_req, pc_next);
            end
            cyc();
        end
        redir_valid = 1'b1; redir_target = 32'h40; ir_ready = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 32'h40) begin n_err++; $display("FAIL bp_redir_next: got %h want 40", pc_next); end
        cyc();
        redir_valid = 1'b0; ir_ready = 1'b0;
        #1;
        n_cmp++; if (ir_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h40) begin
            n_err++; $display("FAIL bp_squash: got v=%b req=%b addr=%h want 0/1/40", ir_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_misalign();
        n_cmp++; if (misalign !== 1'b0) begin n_err++; $display("FAIL mis_before: got %b want 0", misalign); end
        redir_valid = 1'b1; redir_target = 32'h103; imem_ack = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 32'h100) begin n_err++; $display("FAIL mis_next: got %h want 100", pc_next); end
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 32'h100 || misalign !== 1'b1) begin n_err++; $display("FAIL mis_set: got addr=%h mis=%b want 100/1", imem_addr, misalign); end
        redir_valid = 1'b1; redir_target = 32'h300; imem_ack = 1'b1;
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 32'h300 || misalign !== 1'b1) begin n_err++; $display("FAIL mis_sticky1: got addr=%h mis=%b want 300/1", imem_addr, misalign); end
        redir_valid = 1'b1; redir_target = 32'h400;
        cyc();
        redir_valid = 1'b0; imem_ack = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 32'h400) begin n_err++; $display("FAIL mis_pend_next: got %h want 400", pc_next); end
        cyc();
        imem_ack = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 32'h400 || misalign !== 1'b1 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL mis_sticky2: got addr=%h mis=%b v=%b want 400/1/0", imem_addr, misalign, ir_valid);
        end
    endtask

    task automatic test_halt();
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0; halt = 1'b1; ir_ready = 1'b1;
        #1;
        n_cmp++; if (pc_next !== 32'h404) begin n_err++; $display("FAIL halt_step: got %h want 404", pc_next); end
        cyc();
        ir_ready = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL halt_enter: got req=%b v=%b want 0/0", imem_req, ir_valid); end
        cyc();
        n_cmp++; if (imem_req !== 1'b0 || pc_next !== 32'h404) begin n_err++; $display("FAIL halt_stay: got req=%b next=%h want 0/404", imem_req, pc_next); end
        redir_valid = 1'b1; redir_target = 32'h80;
        #1;
        n_cmp++; if (pc_next !== 32'h80) begin n_err++; $display("FAIL halt_redir: got %h want 80", pc_next); end
        cyc();
        redir_valid = 1'b0;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL halt_after_redir: got req=%b want 0", imem_req); end
        halt = 1'b0;
        cyc();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_err++; $display("FAIL halt_resume: got req=%b addr=%h want 1/80", imem_req, imem_addr); end
    endtask

    task automatic test_reset_mid_fetch();
        redir_valid = 1'b1; redir_target = 32'h500;
        cyc();
        redir_valid = 1'b0;
        #1;
        n_cmp++; if (imem_addr !== 32'h80) begin n_err++; $display("FAIL rmf_held: got %h want 80", imem_addr); end
        rst = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || pc_next !== 32'd0 || ir_valid !== 1'b0 || misalign !== 1'b0) begin
            n_err++; $display("FAIL rmf_reset: got req=%b next=%h v=%b mis=%b", imem_req, pc_next, ir_valid, misalign);
        end
        cyc();
        rst = 1'b0; imem_ack = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || pc_next !== 32'd0) begin n_err++; $display("FAIL rmf_boot: got req=%b next=%h want 0/0", imem_req, pc_next); end
        cyc();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'd0 || ir_valid !== 1'b0) begin
            n_err++; $display("FAIL rmf_late_ack: got req=%b addr=%h v=%b want 1/0/0", imem_req, imem_addr, ir_valid);
        end
        cyc();
        imem_ack = 1'b0;
        #1;
        n_cmp++; if (ir_valid !== 1'b1 || ir_pc !== 32'd0 || ir_data !== mem_word(32'd0)) begin
            n_err++; $display("FAIL rmf_pend_cleared: got v=%b pc=%h d=%h want 1/0/%h", ir_valid, ir_pc, ir_data, mem_word(32'd0));
        end
    endtask

    // Randomized run: the model tracks which address should be fetched next,
    // which redirect is waiting behind an outstanding fetch, and which
    // instruction decode should see.
    task automatic test_random();
        logic [31:0] exp_fetch, pend_exp, exp_ir_pc, tgt, want;
        logic        drop, expect_ir, exp_mis, ack, rd, rdy;
        int          wait_cnt, lat, delivered;
        exp_fetch = 32'h0; pend_exp = 32'h0; exp_ir_pc = 32'h0;
        drop = 1'b0; expect_ir = 1'b0; exp_mis = 1'b0;
        wait_cnt = 0; lat = $urandom_range(0, 3); delivered = 0;
        imem_ack = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0; halt = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        for (int c = 0; c < 800; c++) begin
            n_cmp++; if (misalign !== exp_mis) begin n_err++; $display("FAIL rnd_misalign@%0d: got %b want %b", c, misalign, exp_mis); end
            if (expect_ir) begin
                n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL rnd_issue@%0d: got ir_valid=%b want 1", c, ir_valid); end
                expect_ir = 1'b0;
                delivered++;
            end
            imem_ack = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0;
            tgt = $urandom;
            redir_target = tgt;
            if (imem_req) begin
                n_cmp++; if (imem_addr !== exp_fetch || ir_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd_fetch@%0d: got addr=%h v=%b want %h/0", c, imem_addr, ir_valid, exp_fetch);
                end
                ack = (wait_cnt >= lat);
                rd  = ($urandom_range(0, 4) == 0);
                imem_ack = ack; redir_valid = rd;
                #1;
                if (rd && (tgt[1:0] != 2'b00)) exp_mis = 1'b1;
                if (ack) begin
                    if (rd) begin
                        want = tgt & 32'hFFFF_FFFC; exp_fetch = want; drop = 1'b0;
                    end else if (drop) begin
                        want = pend_exp; exp_fetch = want; drop = 1'b0;
                    end else begin
                        want = exp_fetch; expect_ir = 1'b1; exp_ir_pc = exp_fetch;
                    end
                    wait_cnt = 0; lat = $urandom_range(0, 3);
                end else begin
                    want = exp_fetch;
                    if (rd) begin drop = 1'b1; pend_exp = tgt & 32'hFFFF_FFFC; end
                    wait_cnt++;
                end
                n_cmp++; if (pc_next !== want) begin n_err++; $display("FAIL rnd_fetch_next@%0d: got %h want %h", c, pc_next, want); end
            end else if (ir_valid) begin
                n_cmp++; if (ir_pc !== exp_ir_pc || ir_data !== mem_word(exp_ir_pc)) begin
                    n_err++; $display("FAIL rnd_ir@%0d: got pc=%h d=%h want %h/%h", c, ir_pc, ir_data, exp_ir_pc, mem_word(exp_ir_pc));
                end
                rdy = ($urandom_range(0, 1) == 1);
                rd  = ($urandom_range(0, 5) == 0);
                ir_ready = rdy; redir_valid = rd;
                #1;
                if (rd && (tgt[1:0] != 2'b00)) exp_mis = 1'b1;
                if (rd)       want = tgt & 32'hFFFF_FFFC;
                else if (rdy) want = exp_ir_pc + 32'd4;
                else          want = exp_ir_pc;
                if (rd || rdy) exp_fetch = want;
                n_cmp++; if (pc_next !== want) begin n_err++; $display("FAIL rnd_issue_next@%0d: got %h want %h", c, pc_next, want); end
            end else begin
                #1;
                n_cmp++; if (pc_next !== 32'd0) begin n_err++; $display("FAIL rnd_boot@%0d: got %h want 0", c, pc_next); end
            end
            cyc();
        end
        imem_ack = 1'b0; ir_ready = 1'b0; redir_valid = 1'b0;
        n_cmp++; if (delivered < 20) begin n_err++; $display("FAIL rnd_throughput: got %0d instructions want >= 20", delivered); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_zero_wait();
        test_redirect_pending();
        test_backpressure();
        test_misalign();
        test_halt();
        test_reset_mid_fetch();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-stage controller that sequences the pRISC program counter. It drives the PC register's next-value input every cycle and runs the instruction-memory request/acknowledge handshake. It hands fetched instructions to decode through a valid/ready interface. It also applies redirects (branches and jumps) from execute, including redirects that arrive while a fetch is outstanding, and supports halting at instruction boundaries.

## Interface
- BOOT_ADDR, 32'h0000_0000, first fetch address after reset
- STEP, 32'd4, sequential PC increment
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pc_cur  in  32  current PC, from the PC register output (PC register resets to 32'hFFFF_FFFC)
- pc_next  out  32  next PC, to the PC register input; PC register loads it every clock
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch done, imem_rdata valid
- imem_rdata  in  32  fetched instruction word
- ir_valid  out  1  instruction available to decode
- ir_data  out  32  instruction word
- ir_pc  out  32  address of ir_data
- ir_ready  in  1  decode accepts instruction
- redir_valid  in  1  redirect request, single-cycle pulse or level
- redir_target  in  32  redirect address
- halt  in  1  level: stop fetching at the next boundary
- misalign  out  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- States: BOOT, FETCH, ISSUE, HALTED. Reset enters BOOT.
- Internal registers: pend_valid and pend_target (deferred redirect).
- Redirect target use:
  - Every accepted target is used with bits [1:0] forced to 0.
  - A nonzero [1:0] sets misalign, which clears only on rst.
- "Enter FETCH" below means: go to HALTED instead if halt=1 in that cycle.
- BOOT:
  - pc_next=BOOT_ADDR; redirects ignored.
  - Next: enter FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_cur, pc_next=pc_cur. Address is held stable until imem_ack.
  - If redir_valid and no ack: set pend_valid, pend_target=target. A newer redirect overwrites pend_target.
  - On imem_ack, with priority order:
    1. If redir_valid this cycle: discard data, pc_next=redir_target, clear pend, enter FETCH.
    2. Else if pend_valid: discard data, pc_next=pend_target, clear pend, enter FETCH.
    3. Else: ir_data<=imem_rdata, ir_pc<=pc_cur, ir_valid<=1, go ISSUE.
- ISSUE:
  - imem_req=0, pc_next=pc_cur; ir_* held stable while waiting.
  - redir_valid (priority over ir_ready): ir_valid<=0, pc_next=redir_target, enter FETCH. The handshake does not complete even if ir_ready=1.
  - Else if ir_ready: ir_valid<=0, pc_next=pc_cur+STEP (mod 2^32, wraps), enter FETCH.
- HALTED:
  - imem_req=0, ir_valid=0.
  - redir_valid: pc_next=redir_target and stay HALTED. Otherwise pc_next=pc_cur.
  - halt=0: go FETCH.
- Reset mid-operation:
  - Any outstanding fetch is abandoned; a later imem_ack in BOOT is ignored.
  - pend is cleared.

## Timing
- Reset values: imem_req=0, ir_valid=0, ir_data=0, ir_pc=0, misalign=0, pend_valid=0, pend_target=0. pc_next=BOOT_ADDR, since the state is BOOT.
- pc_next, imem_req and imem_addr are combinational from state, pc_cur and inputs. ir_*, misalign and pend are registered.
- Zero-wait memory (ack in the same cycle as req) is supported.
- Throughput is one instruction per 2 cycles at best (FETCH + ISSUE).
- First request: the first cycle after rst falls is BOOT; imem_req=1 with imem_addr=BOOT_ADDR one cycle later.
- Redirect-to-request latency is 1 cycle, except under a pending fetch, where it waits for imem_ack + 1 cycle.
- ir_valid falls the cycle after handshake completion; the instruction is presented for at least 1 cycle.

## Test plan
- Reset release, pc_cur=FFFF_FFFC:
  - Cycle 0: pc_next=0.
  - Cycle 1: imem_req=1, imem_addr=0.
  - All registered outputs are 0 during rst.
- Zero-wait memory, ir_ready=1:
  - ir_pc sequence is 0,4,8,C with ir_valid asserted every other cycle.
  - Force pc_cur=FFFF_FFFC in ISSUE: pc_next=0 (wrap).
- Fetch of 0x8 with ack delayed 3 cycles; redir 0x100 in wait cycle 1, then 0x200 in wait cycle 2:
  - Returning data is dropped and ir_valid stays 0.
  - Next imem_addr=0x200.
- Backpressure, ir_ready=0 for 5 cycles:
  - ir_valid=1 and ir_data/ir_pc constant; imem_req=0; pc_next=pc_cur.
  - Then redir 0x40 with ir_ready=1 in the same cycle: the instruction is squashed and the next fetch is at 0x40.
- Redirect to 0x103:
  - Fetch address is 0x100 and misalign=1.
  - misalign stays 1 across later aligned redirects until rst.
- halt=1 during ISSUE:
  - After the handshake, state is HALTED with imem_req=0.
  - redir 0x80 while halted, then halt=0: next imem_addr=0x80.
  - rst asserted mid-FETCH: returns to BOOT, and a late ack is ignored.
